// File: rtl/prng_seg_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module : prng_seg_addsub_pipe
// Brief  : Pipelined lane-segmented add/subtract over W bits in 32-bit chunks.
// Rev    : 1.0
// ============================================================================
module prng_seg_addsub_pipe #(
  parameter int W           = 256,
  parameter int CHUNK_PER_S = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      a_i,
  input  logic [W-1:0]      b_i,
  input  logic              sub_i,
  input  logic [2:0]        width_i,
  input  logic [7:0]        tag_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      sum_o,
  output logic [W/32-1:0]   carry_o,
  output logic [7:0]        tag_o
);

  localparam int NCH    = W / 32;
  localparam int STAGES = NCH / CHUNK_PER_S;

  // Stage inputs: index 0 comes from the ports, index s from stage s-1 registers.
  logic           src_vld [STAGES];
  logic           src_sub [STAGES];
  logic [2:0]     src_wid [STAGES];
  logic [7:0]     src_tag [STAGES];
  logic [W-1:0]   src_a   [STAGES];
  logic [W-1:0]   src_b   [STAGES];
  logic [W-1:0]   src_sum [STAGES];
  logic [NCH-1:0] src_cf  [STAGES];
  logic           src_cy  [STAGES];

  logic [W-1:0]   sum_d [STAGES];
  logic [NCH-1:0] cf_d  [STAGES];
  logic           cy_d  [STAGES];

  logic           vld_q [STAGES];
  logic           sub_q [STAGES];
  logic [2:0]     wid_q [STAGES];
  logic [7:0]     tag_q [STAGES];
  logic [W-1:0]   a_q   [STAGES];
  logic [W-1:0]   b_q   [STAGES];
  logic [W-1:0]   sum_q [STAGES];
  logic [NCH-1:0] cf_q  [STAGES];
  logic           cy_q  [STAGES];

  function automatic logic [2:0] norm_width(input logic [2:0] w);
    case (w)
      3'b001, 3'b011, 3'b111: return w;
      default:                return 3'b000;
    endcase
  endfunction

  // Lane-low chunks for width code {is256,is128,is64}; repeats every 8 chunks.
  function automatic logic [NCH-1:0] lane_low(input logic [2:0] w);
    logic [NCH-1:0] m;
    for (int c = 0; c < NCH; c++) begin
      m[c] = (c % 8 == 0)
          || ((c % 2 == 1) && !w[0])
          || ((c % 4 == 2) && !w[1])
          || ((c % 8 == 4) && !w[2]);
    end
    return m;
  endfunction

  always_comb begin
    src_vld[0] = in_valid;
    src_sub[0] = sub_i;
    src_wid[0] = norm_width(width_i);
    src_tag[0] = tag_i;
    src_a[0]   = a_i;
    src_b[0]   = b_i;
    src_sum[0] = '0;
    src_cf[0]  = '0;
    src_cy[0]  = 1'b0;
    for (int s = 1; s < STAGES; s++) begin
      src_vld[s] = vld_q[s-1];
      src_sub[s] = sub_q[s-1];
      src_wid[s] = wid_q[s-1];
      src_tag[s] = tag_q[s-1];
      src_a[s]   = a_q[s-1];
      src_b[s]   = b_q[s-1];
      src_sum[s] = sum_q[s-1];
      src_cf[s]  = cf_q[s-1];
      src_cy[s]  = cy_q[s-1];
    end
  end

  always_comb begin
    logic           cy;
    logic [NCH-1:0] low;
    logic [NCH:0]   lowx;
    logic [31:0]    opb;
    logic [32:0]    t;
    cy   = 1'b0;
    low  = '0;
    lowx = '0;
    opb  = '0;
    t    = '0;
    for (int s = 0; s < STAGES; s++) begin
      sum_d[s] = src_sum[s];
      cf_d[s]  = src_cf[s];
      cy       = src_cy[s];
      low      = lane_low(src_wid[s]);
      // A chunk is a lane top when the next chunk starts a lane (or it is the last chunk).
      lowx     = {1'b1, low};
      for (int j = 0; j < CHUNK_PER_S; j++) begin
        if (low[s*CHUNK_PER_S + j]) begin
          cy = src_sub[s];
        end
        opb = src_sub[s] ? ~src_b[s][(s*CHUNK_PER_S + j)*32 +: 32]
                         :  src_b[s][(s*CHUNK_PER_S + j)*32 +: 32];
        t   = {1'b0, src_a[s][(s*CHUNK_PER_S + j)*32 +: 32]} + {1'b0, opb} + {32'd0, cy};
        sum_d[s][(s*CHUNK_PER_S + j)*32 +: 32] = t[31:0];
        cy  = t[32];
        cf_d[s][s*CHUNK_PER_S + j] = lowx[s*CHUNK_PER_S + j + 1] ? cy : 1'b0;
      end
      cy_d[s] = cy;
    end
  end

  // Any stall freezes every stage at once, so bubbles stay where they are.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        vld_q[s] <= 1'b0;
        sub_q[s] <= 1'b0;
        wid_q[s] <= 3'b000;
        tag_q[s] <= 8'h00;
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        sum_q[s] <= '0;
        cf_q[s]  <= '0;
        cy_q[s]  <= 1'b0;
      end
    end else if (in_ready) begin
      for (int s = 0; s < STAGES; s++) begin
        vld_q[s] <= src_vld[s];
        sub_q[s] <= src_sub[s];
        wid_q[s] <= src_wid[s];
        tag_q[s] <= src_tag[s];
        a_q[s]   <= src_a[s];
        b_q[s]   <= src_b[s];
        sum_q[s] <= sum_d[s];
        cf_q[s]  <= cf_d[s];
        cy_q[s]  <= cy_d[s];
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum_o     = sum_q[STAGES-1];
  assign carry_o   = cf_q[STAGES-1];
  assign tag_o     = tag_q[STAGES-1];
  assign in_ready  = !(out_valid && !out_ready);

endmodule
`default_nettype wire

// File: tb/tb_prng_seg_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_prng_seg_addsub_pipe
// Brief  : Directed vectors, stall/reset sequences and random ops against a lane model.
// Rev    : 1.0
// ============================================================================
module tb_prng_seg_addsub_pipe;

  localparam int W      = 256;
  localparam int NCH    = 8;
  localparam int STAGES = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           op_sub;
  logic [2:0]     op_w;
  logic [7:0]     op_tag;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   sum_o;
  logic [NCH-1:0] carry_o;
  logic [7:0]     tag_o;

  logic ready_ctl;
  logic rand_ready;
  logic rnd_ready;
  logic mon_en;

  int n_checks = 0;
  int n_err    = 0;
  int stall_waits = 0;

  typedef struct {
    logic [255:0] sum;
    logic [7:0]   cf;
    logic [7:0]   tag;
  } exp_t;

  typedef struct {
    logic [255:0] a;
    logic [255:0] b;
    logic         sub;
    logic [2:0]   w;
    logic [255:0] sum;
    logic [7:0]   cf;
    string        name;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];

  prng_seg_addsub_pipe #(.W(W), .CHUNK_PER_S(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_i       (op_a),
    .b_i       (op_b),
    .sub_i     (op_sub),
    .width_i   (op_w),
    .tag_i     (op_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_o     (sum_o),
    .carry_o   (carry_o),
    .tag_o     (tag_o)
  );

  always #5 clk = ~clk;

  assign out_ready = rand_ready ? rnd_ready : ready_ctl;

  always @(posedge clk) begin
    #1 rnd_ready = ($urandom_range(0, 2) != 0);
  end

  // Lane-level reference: whole lanes as plain integers, no chunk ripple.
  function automatic exp_t model(input logic [255:0] ma, input logic [255:0] mb,
                                 input logic ms, input logic [2:0] mw, input logic [7:0] mt);
    exp_t e;
    int L;
    logic [256:0] mask, al, bl, r;
    case (mw)
      3'b001:  L = 64;
      3'b011:  L = 128;
      3'b111:  L = 256;
      default: L = 32;
    endcase
    e.sum = '0;
    e.cf  = '0;
    e.tag = mt;
    mask  = (257'd1 << L) - 257'd1;
    for (int base = 0; base < 256; base += L) begin
      al = ({1'b0, ma} >> base) & mask;
      bl = ({1'b0, mb} >> base) & mask;
      if (ms) begin
        r = (al - bl) & mask;
        e.cf[(base + L) / 32 - 1] = (al >= bl);
      end else begin
        r = al + bl;
        e.cf[(base + L) / 32 - 1] = r[L];
        r = r & mask;
      end
      e.sum = e.sum | (r[255:0] << base);
    end
    return e;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  // Presents one op (called just after a rising edge); holds it until accepted.
  task automatic drive_op(input logic [255:0] ta, input logic [255:0] tb2,
                          input logic ts, input logic [2:0] tw, input logic [7:0] tt);
    int g;
    g = 0;
    op_a = ta; op_b = tb2; op_sub = ts; op_w = tw; op_tag = tt;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && g < 100) begin
      g++;
      stall_waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      n_err++;
      $display("FAIL drive_timeout: in_ready=%0b required 1", in_ready);
    end else begin
      exp_q.push_back(model(ta, tb2, ts, tw, tt));
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      @(posedge clk);
      #1 g++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_output: tag %0d with no pending op", tag_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("stream_sum", sum_o, e.sum);
        chk("stream_carry", carry_o, e.cf);
        chk("stream_tag", tag_o, e.tag);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    exp_t ef;
    rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; op_sub = 1'b0; op_w = 3'b000;
    op_tag = 8'h00; ready_ctl = 1'b1; rand_ready = 1'b0; mon_en = 1'b0;

    vecs.push_back('{{8{32'hFFFFFFFF}}, {8{32'h1}}, 1'b0, 3'b000, 256'h0, 8'hFF, "add32_wrap"});
    vecs.push_back('{{8{32'hFFFFFFFF}}, 256'h1, 1'b0, 3'b111, 256'h0, 8'h80, "add256_wrap"});
    vecs.push_back('{256'hFFFFFFFF, 256'h1, 1'b0, 3'b111, 256'h1_0000_0000, 8'h00, "add256_cross"});
    vecs.push_back('{{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0F1E2D3C4B5A6978, 64'h0},
                     {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0F1E2D3C4B5A6978, 64'h1},
                     1'b1, 3'b001, {192'h0, 64'hFFFFFFFF_FFFFFFFF}, 8'hA8, "sub64_borrow"});
    vecs.push_back('{{8{32'hFFFFFFFF}}, {8{32'h1}}, 1'b0, 3'b010, 256'h0, 8'hFF, "illegal010"});
    vecs.push_back('{{128'h0, {4{32'hFFFFFFFF}}}, 256'h1, 1'b0, 3'b011, 256'h0, 8'h08, "add128_wrap"});
    vecs.push_back('{{8{32'd5}}, {8{32'd3}}, 1'b1, 3'b000, {8{32'd2}}, 8'hFF, "sub32"});
    vecs.push_back('{256'h0, 256'h1, 1'b1, 3'b111, {8{32'hFFFFFFFF}}, 8'h00, "sub256_borrow"});
    vecs.push_back('{{8{32'hFFFFFFFF}}, {4{64'h1}}, 1'b0, 3'b001, 256'h0, 8'hAA, "add64_wrap"});
    vecs.push_back('{{8{32'hFFFFFFFF}}, {4{64'h1}}, 1'b0, 3'b110, {4{64'hFFFFFFFF_00000000}},
                     8'h55, "illegal110"});

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_sum", sum_o, 0);
    chk("reset_carry", carry_o, 0);
    chk("reset_tag", tag_o, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      int lat;
      @(posedge clk);
      #1;
      op_a = vecs[i].a; op_b = vecs[i].b; op_sub = vecs[i].sub; op_w = vecs[i].w;
      op_tag = 8'h40 + 8'(i);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 50) begin
        @(posedge clk);
        #1 lat++;
      end
      chk({vecs[i].name, "_latency"}, lat, STAGES);
      chk({vecs[i].name, "_sum"}, sum_o, vecs[i].sum);
      chk({vecs[i].name, "_carry"}, carry_o, vecs[i].cf);
      chk({vecs[i].name, "_tag"}, tag_o, 8'h40 + 8'(i));
    end
    @(posedge clk);
    #1;

    // Fill the pipe with the consumer stalled, hold for 5 cycles, then resume.
    mon_en = 1'b1;
    ready_ctl = 1'b0;
    for (int i = 0; i < STAGES; i++)
      drive_op(rand256(), rand256(), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'h80 + 8'(i));
    @(negedge clk);
    ef = exp_q[0];
    chk("stall_full_valid", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      chk("stall_in_ready", in_ready, 0);
      chk("stall_sum_hold", sum_o, ef.sum);
      chk("stall_carry_hold", carry_o, ef.cf);
      chk("stall_tag_hold", tag_o, ef.tag);
      @(negedge clk);
    end
    @(posedge clk);
    #1 ready_ctl = 1'b1;
    stall_waits = 0;
    for (int i = 0; i < STAGES; i++)
      drive_op(rand256(), rand256(), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'h90 + 8'(i));
    chk("resume_no_wait", stall_waits, 0);
    drain("stall_drain");

    stall_waits = 0;
    for (int i = 0; i < 16; i++)
      drive_op(rand256(), rand256(), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'(i));
    chk("b2b_no_wait", stall_waits, 0);
    drain("b2b_drain");

    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++)
      drive_op(rand256(), rand256(), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'h20 + 8'(i));
    drain("random_ready_drain");
    rand_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset with three ops in flight: none of them may emerge.
    mon_en = 1'b0;
    for (int i = 0; i < 3; i++)
      drive_op(rand256(), rand256(), 1'b0, 3'b111, 8'hE0 + 8'(i));
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) bad = 1'b1;
    end
    chk("rst_mid_no_output", bad, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    drive_op({8{32'h89ABCDEF}}, {8{32'h12345678}}, 1'b1, 3'b011, 8'hF0);
    drain("rst_mid_new_op");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
